// File: rtl/ysyx_25040129_lsu_ctrl_pkg.sv
// Shared encodings, FSM state constants and decode helpers for the LSU.
// Imported by the LSU control FSM and the lane/alignment sub-module.
package ysyx_25040129_lsu_ctrl_pkg;

  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_LB   = 3'b001;
  localparam logic [2:0] RD_LH   = 3'b010;
  localparam logic [2:0] RD_LW   = 3'b011;
  localparam logic [2:0] RD_LBU  = 3'b100;
  localparam logic [2:0] RD_LHU  = 3'b101;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_SB   = 2'b01;
  localparam logic [1:0] WR_SH   = 2'b10;
  localparam logic [1:0] WR_SW   = 2'b11;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE   = 2'd0;
  localparam lsu_state_t ST_ACCESS = 2'd1;
  localparam lsu_state_t ST_WAIT   = 2'd2;
  localparam lsu_state_t ST_DONE   = 2'd3;

  // Encodings 110/111 are illegal and collapse to "no read".
  function automatic logic [2:0] lsu_read_norm(input logic [2:0] op);
    return (op > RD_LHU) ? RD_NONE : op;
  endfunction

  // Expects a normalised read op; the write op only matters when there is no read.
  function automatic logic lsu_misaligned(input logic [2:0] rd_op, input logic [1:0] wr_op,
                                          input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (rd_op)
      RD_LH, RD_LHU: mis = addr_lo[0];
      RD_LW:         mis = |addr_lo;
      RD_NONE: begin
        case (wr_op)
          WR_SH:   mis = addr_lo[0];
          WR_SW:   mis = |addr_lo;
          default: mis = 1'b0;
        endcase
      end
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_25040129_lsu_ctrl_if.sv
// Bundles the EXU request, memory bus and WBU writeback channels of the LSU.
// master = the LSU itself, slave = its surroundings (EXU, memory, WBU).
interface ysyx_25040129_lsu_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              is_req_valid_from_exu;
  logic              is_req_ready_to_exu;
  logic [31:0]       pc_in_lsu;
  logic [DATA_W-1:0] result_in_lsu;
  logic [DATA_W-1:0] lsu_write_data_in_lsu;
  logic [2:0]        lsu_read_in_lsu;
  logic [1:0]        lsu_write_in_lsu;
  logic [4:0]        rd_in_lsu;
  logic              reg_write_in_lsu;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              is_req_valid_to_wbu;
  logic              is_req_ready_from_wbu;
  logic [31:0]       pc_out_lsu;
  logic [DATA_W-1:0] result_out_lsu;
  logic [4:0]        rd_out_lsu;
  logic              reg_write_out_lsu;
  logic              misalign_fault_out_lsu;

  modport master (
    input  is_req_valid_from_exu, pc_in_lsu, result_in_lsu, lsu_write_data_in_lsu,
           lsu_read_in_lsu, lsu_write_in_lsu, rd_in_lsu, reg_write_in_lsu,
           mem_req_ready, mem_rvalid, mem_rdata, is_req_ready_from_wbu,
    output is_req_ready_to_exu, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
           is_req_valid_to_wbu, pc_out_lsu, result_out_lsu, rd_out_lsu, reg_write_out_lsu,
           misalign_fault_out_lsu
  );

  modport slave (
    output is_req_valid_from_exu, pc_in_lsu, result_in_lsu, lsu_write_data_in_lsu,
           lsu_read_in_lsu, lsu_write_in_lsu, rd_in_lsu, reg_write_in_lsu,
           mem_req_ready, mem_rvalid, mem_rdata, is_req_ready_from_wbu,
    input  is_req_ready_to_exu, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
           is_req_valid_to_wbu, pc_out_lsu, result_out_lsu, rd_out_lsu, reg_write_out_lsu,
           misalign_fault_out_lsu
  );

endinterface

// File: rtl/ysyx_25040129_lsu_align.sv
// Combinational byte-lane logic: store strobes/data replication, load extraction
// with sign/zero extension, and the misalignment flag.
module ysyx_25040129_lsu_align
  import ysyx_25040129_lsu_ctrl_pkg::*;
(
  input  logic [2:0]  i_rd_op,
  input  logic [1:0]  i_wr_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_wstrb = 4'b0000;
    o_wdata = 32'h0;
    case (i_wr_op)
      WR_SB: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      WR_SH: begin
        o_wstrb = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_wdata[15:0]}};
      end
      WR_SW: begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
      end
      default: ;
    endcase

    o_rdata = 32'h0;
    case (i_rd_op)
      RD_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
      RD_LH:   o_rdata = {{16{w_half[15]}}, w_half};
      RD_LW:   o_rdata = i_rdata;
      RD_LBU:  o_rdata = {24'h0, w_byte};
      RD_LHU:  o_rdata = {16'h0, w_half};
      default: ;
    endcase

    o_misalign = lsu_misaligned(i_rd_op, i_wr_op, i_addr_lo);
  end

endmodule

// File: rtl/ysyx_25040129_lsu_ctrl.sv
// LSU control FSM: takes one instruction from EXU, runs at most one memory
// transaction on a single-outstanding bus, and offers the result to WBU.
module ysyx_25040129_lsu_ctrl
  import ysyx_25040129_lsu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_25040129_lsu_ctrl_if.master      lsu_bus
);

  lsu_state_t        r_state;
  lsu_state_t        w_state_next;
  logic [31:0]       r_pc;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_result;
  logic [2:0]        r_rd_op;
  logic [1:0]        r_wr_op;
  logic [4:0]        r_rd;
  logic              r_reg_write;
  logic              r_fault;

  logic              w_idle;
  logic              w_hs;
  logic [2:0]        w_rd_op;
  logic [1:0]        w_wr_op;
  logic              w_is_mem;
  logic              w_is_store;
  logic [2:0]        w_sel_rd;
  logic [1:0]        w_sel_wr;
  logic [1:0]        w_sel_lo;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load_data;
  logic              w_misalign;

  // Reads win over writes; an illegal read encoding falls back to the write field.
  assign w_rd_op    = lsu_read_norm(lsu_bus.lsu_read_in_lsu);
  assign w_wr_op    = (w_rd_op != RD_NONE) ? WR_NONE : lsu_bus.lsu_write_in_lsu;
  assign w_is_mem   = (w_rd_op != RD_NONE) || (w_wr_op != WR_NONE);
  assign w_is_store = (w_wr_op != WR_NONE);
  assign w_idle     = (r_state == ST_IDLE);
  assign w_hs       = w_idle && lsu_bus.is_req_valid_from_exu;

  // In IDLE the aligner judges the incoming op; afterwards it works on the held op.
  assign w_sel_rd = w_idle ? w_rd_op : r_rd_op;
  assign w_sel_wr = w_idle ? w_wr_op : r_wr_op;
  assign w_sel_lo = w_idle ? lsu_bus.result_in_lsu[1:0] : r_addr[1:0];

  ysyx_25040129_lsu_align u_align (
    .i_rd_op    (w_sel_rd),
    .i_wr_op    (w_sel_wr),
    .i_addr_lo  (w_sel_lo),
    .i_wdata    (r_wdata),
    .i_rdata    (lsu_bus.mem_rdata),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_rdata    (w_load_data),
    .o_misalign (w_misalign)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) w_state_next = (w_is_mem && !w_misalign) ? ST_ACCESS : ST_DONE;
      end
      ST_ACCESS: if (lsu_bus.mem_req_ready) w_state_next = ST_WAIT;
      ST_WAIT:   if (lsu_bus.mem_rvalid) w_state_next = ST_DONE;
      ST_DONE:   if (lsu_bus.is_req_ready_from_wbu) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_result    <= '0;
      r_rd_op     <= RD_NONE;
      r_wr_op     <= WR_NONE;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_hs) begin
        r_pc        <= lsu_bus.pc_in_lsu;
        r_addr      <= lsu_bus.result_in_lsu;
        r_wdata     <= lsu_bus.lsu_write_data_in_lsu;
        r_rd_op     <= w_rd_op;
        r_wr_op     <= w_wr_op;
        r_rd        <= lsu_bus.rd_in_lsu;
        r_fault     <= w_misalign;
        // Misaligned ops report the address; loads overwrite this in WAIT.
        r_result    <= (w_is_store && !w_misalign) ? '0 : lsu_bus.result_in_lsu;
        r_reg_write <= (w_is_store || w_misalign) ? 1'b0 : lsu_bus.reg_write_in_lsu;
      end else if ((r_state == ST_WAIT) && lsu_bus.mem_rvalid) begin
        r_result <= w_load_data;
      end
    end
  end

  assign lsu_bus.is_req_ready_to_exu    = w_idle;
  assign lsu_bus.mem_req_valid          = (r_state == ST_ACCESS);
  assign lsu_bus.mem_addr               = {r_addr[ADDR_W-1:2], 2'b00};
  assign lsu_bus.mem_wen                = lsu_bus.mem_req_valid && (r_wr_op != WR_NONE);
  assign lsu_bus.mem_wstrb              = lsu_bus.mem_req_valid ? w_wstrb : 4'b0000;
  assign lsu_bus.mem_wdata              = lsu_bus.mem_req_valid ? w_wdata : '0;
  assign lsu_bus.is_req_valid_to_wbu    = (r_state == ST_DONE);
  assign lsu_bus.pc_out_lsu             = r_pc;
  assign lsu_bus.result_out_lsu         = r_result;
  assign lsu_bus.rd_out_lsu             = r_rd;
  assign lsu_bus.reg_write_out_lsu      = r_reg_write;
  assign lsu_bus.misalign_fault_out_lsu = r_fault;

endmodule

// File: tb/tb_ysyx_25040129_lsu_ctrl.sv
// Directed vector bench for the LSU: table of single transactions with an
// always-ready memory, plus hand sequences for stalls and async reset.
module tb_ysyx_25040129_lsu_ctrl;
  import ysyx_25040129_lsu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_25040129_lsu_ctrl_if bus ();

  ysyx_25040129_lsu_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .lsu_bus (bus)
  );

  typedef struct {
    logic [2:0]  rd_op;
    logic [1:0]  wr_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_mem;
    logic        exp_wen;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_result;
    logic        exp_rw;
    logic        exp_fault;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_wen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] rd_op, input logic [1:0] wr_op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc, input logic [4:0] rd);
    @(negedge clk);
    bus.lsu_read_in_lsu       = rd_op;
    bus.lsu_write_in_lsu      = wr_op;
    bus.result_in_lsu         = addr;
    bus.lsu_write_data_in_lsu = wdata;
    bus.pc_in_lsu             = pc;
    bus.rd_in_lsu             = rd;
    bus.reg_write_in_lsu      = 1'b1;
    chk("exu_ready_before_issue", {31'h0, bus.is_req_ready_to_exu}, 32'd1);
    bus.is_req_valid_from_exu = 1'b1;
    @(posedge clk);
    #1 bus.is_req_valid_from_exu = 1'b0;
  endtask

  // Returns with the bench sitting at a negedge where WBU valid is high.
  task automatic wait_wbu(output int lat, output bit saw_req);
    lat     = 1;
    saw_req = 1'b0;
    while (1) begin
      @(negedge clk);
      if (bus.mem_req_valid) begin
        saw_req   = 1'b1;
        req_addr  = bus.mem_addr;
        req_wdata = bus.mem_wdata;
        req_wstrb = bus.mem_wstrb;
        req_wen   = bus.mem_wen;
      end
      if (bus.is_req_valid_to_wbu) break;
      lat++;
      if (lat > 40) begin
        total++;
        bad++;
        $display("FAIL wbu_timeout: got no wbu valid expected one within 40 cycles");
        break;
      end
    end
  endtask

  task automatic accept();
    bus.is_req_ready_from_wbu = 1'b1;
    @(posedge clk);
    #1 bus.is_req_ready_from_wbu = 1'b0;
  endtask

  vec_t vecs[14];
  int   lat;
  bit   saw;

  initial begin
    vecs[0]  = '{3'b000, 2'b00, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0000_1234, 1, 0};
    vecs[1]  = '{RD_LB,  WR_NONE, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 1, 0, 4'h0, 32'h0,
                 32'hFFFF_FF80, 1, 0};
    vecs[2]  = '{RD_LBU, WR_NONE, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 1, 0, 4'h0, 32'h0,
                 32'h0000_0080, 1, 0};
    vecs[3]  = '{RD_LH,  WR_NONE, 32'h8000_0002, 32'h0, 32'h80AA_BBCC, 1, 0, 4'h0, 32'h0,
                 32'hFFFF_80AA, 1, 0};
    vecs[4]  = '{RD_LHU, WR_NONE, 32'h8000_0000, 32'h0, 32'h1234_F00D, 1, 0, 4'h0, 32'h0,
                 32'h0000_F00D, 1, 0};
    vecs[5]  = '{RD_LW,  WR_NONE, 32'h8000_0004, 32'h0, 32'hCAFE_BABE, 1, 0, 4'h0, 32'h0,
                 32'hCAFE_BABE, 1, 0};
    vecs[6]  = '{RD_NONE, WR_SB, 32'h8000_0001, 32'h0000_00A5, 32'h0, 1, 1, 4'b0010,
                 32'hA5A5_A5A5, 32'h0, 0, 0};
    vecs[7]  = '{RD_NONE, WR_SW, 32'h8000_0008, 32'h1122_3344, 32'h0, 1, 1, 4'b1111,
                 32'h1122_3344, 32'h0, 0, 0};
    vecs[8]  = '{RD_LW,  WR_NONE, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0,
                 32'h8000_0001, 0, 1};
    vecs[9]  = '{RD_NONE, WR_SH, 32'h8000_0003, 32'h0000_1111, 32'h0, 0, 0, 4'h0, 32'h0,
                 32'h8000_0003, 0, 1};
    vecs[10] = '{RD_LH,  WR_NONE, 32'h8000_0005, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0,
                 32'h8000_0005, 0, 1};
    vecs[11] = '{RD_LBU, WR_SW, 32'h8000_0000, 32'h7777_7777, 32'h0000_00FF, 1, 0, 4'h0, 32'h0,
                 32'h0000_00FF, 1, 0};
    vecs[12] = '{3'b110, 2'b00, 32'h0000_0055, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0,
                 32'h0000_0055, 1, 0};
    vecs[13] = '{RD_LB,  WR_NONE, 32'h8000_0001, 32'h0, 32'h1234_5678, 1, 0, 4'h0, 32'h0,
                 32'h0000_0056, 1, 0};

    rst                       = 1'b0;
    bus.is_req_valid_from_exu = 1'b0;
    bus.pc_in_lsu             = '0;
    bus.result_in_lsu         = '0;
    bus.lsu_write_data_in_lsu = '0;
    bus.lsu_read_in_lsu       = '0;
    bus.lsu_write_in_lsu      = '0;
    bus.rd_in_lsu             = '0;
    bus.reg_write_in_lsu      = 1'b0;
    bus.mem_req_ready         = 1'b1;
    bus.mem_rvalid            = 1'b1;
    bus.mem_rdata             = '0;
    bus.is_req_ready_from_wbu = 1'b0;
    #22;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_exu_ready", {31'h0, bus.is_req_ready_to_exu}, 32'd1);
    chk("reset_mem_req_valid", {31'h0, bus.mem_req_valid}, 32'd0);
    chk("reset_wbu_valid", {31'h0, bus.is_req_valid_to_wbu}, 32'd0);
    chk("reset_result", bus.result_out_lsu, 32'h0);
    chk("reset_fault", {31'h0, bus.misalign_fault_out_lsu}, 32'd0);

    // Memory always ready with rvalid held high: rvalid in ACCESS must be ignored.
    for (int i = 0; i < 14; i++) begin
      bus.mem_rdata = vecs[i].rdata;
      issue(vecs[i].rd_op, vecs[i].wr_op, vecs[i].addr, vecs[i].wdata, 32'h1000 + i * 4,
            5'(i + 1));
      wait_wbu(lat, saw);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_mem ? 32'd3 : 32'd1);
      chk($sformatf("v%0d_mem_req_seen", i), {31'h0, saw}, {31'h0, vecs[i].exp_mem});
      if (vecs[i].exp_mem) begin
        chk($sformatf("v%0d_mem_addr", i), req_addr, {vecs[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_mem_wen", i), {31'h0, req_wen}, {31'h0, vecs[i].exp_wen});
        if (vecs[i].exp_wen) begin
          chk($sformatf("v%0d_wstrb", i), {28'h0, req_wstrb}, {28'h0, vecs[i].exp_wstrb});
          chk($sformatf("v%0d_wdata", i), req_wdata, vecs[i].exp_wdata);
        end
      end
      chk($sformatf("v%0d_result", i), bus.result_out_lsu, vecs[i].exp_result);
      chk($sformatf("v%0d_reg_write", i), {31'h0, bus.reg_write_out_lsu},
          {31'h0, vecs[i].exp_rw});
      chk($sformatf("v%0d_fault", i), {31'h0, bus.misalign_fault_out_lsu},
          {31'h0, vecs[i].exp_fault});
      chk($sformatf("v%0d_pc", i), bus.pc_out_lsu, 32'h1000 + i * 4);
      chk($sformatf("v%0d_rd", i), {27'h0, bus.rd_out_lsu}, 32'(i + 1));
      accept();
    end

    // SH with the memory stalling the request for 3 cycles.
    bus.mem_req_ready = 1'b0;
    issue(RD_NONE, WR_SH, 32'h8000_0002, 32'hDEAD_BEEF, 32'h3000, 5'd9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sh_stall_req_valid", {31'h0, bus.mem_req_valid}, 32'd1);
      chk("sh_stall_addr", bus.mem_addr, 32'h8000_0000);
      chk("sh_stall_wstrb", {28'h0, bus.mem_wstrb}, 32'h0000_000C);
      chk("sh_stall_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
      chk("sh_stall_wen", {31'h0, bus.mem_wen}, 32'd1);
    end
    bus.mem_req_ready = 1'b1;
    wait_wbu(lat, saw);
    chk("sh_result", bus.result_out_lsu, 32'h0);
    chk("sh_reg_write", {31'h0, bus.reg_write_out_lsu}, 32'd0);
    accept();

    // WBU back-pressure with a second EXU request waiting.
    issue(RD_NONE, WR_NONE, 32'h0000_ABCD, 32'h0, 32'h4000, 5'd3);
    wait_wbu(lat, saw);
    bus.result_in_lsu         = 32'h0000_9999;
    bus.pc_in_lsu             = 32'h5000;
    bus.is_req_valid_from_exu = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_wbu_valid", {31'h0, bus.is_req_valid_to_wbu}, 32'd1);
      chk("stall_result", bus.result_out_lsu, 32'h0000_ABCD);
      chk("stall_pc", bus.pc_out_lsu, 32'h4000);
      chk("stall_exu_ready", {31'h0, bus.is_req_ready_to_exu}, 32'd0);
    end
    accept();
    bus.is_req_valid_from_exu = 1'b0;
    chk("after_wbu_hs_exu_ready", {31'h0, bus.is_req_ready_to_exu}, 32'd1);
    chk("after_wbu_hs_wbu_valid", {31'h0, bus.is_req_valid_to_wbu}, 32'd0);

    // Asynchronous reset while waiting for the read response.
    bus.mem_rvalid = 1'b0;
    issue(RD_LW, WR_NONE, 32'h8000_0010, 32'h0, 32'h2000, 5'd7);
    @(posedge clk);
    #2;
    chk("wait_mem_req_valid", {31'h0, bus.mem_req_valid}, 32'd0);
    chk("wait_wbu_valid", {31'h0, bus.is_req_valid_to_wbu}, 32'd0);
    chk("wait_pc_held", bus.pc_out_lsu, 32'h2000);
    rst = 1'b0;
    #1;
    chk("async_rst_pc", bus.pc_out_lsu, 32'h0);
    chk("async_rst_rd", {27'h0, bus.rd_out_lsu}, 32'h0);
    chk("async_rst_result", bus.result_out_lsu, 32'h0);
    chk("async_rst_mem_addr", bus.mem_addr, 32'h0);
    chk("async_rst_wbu_valid", {31'h0, bus.is_req_valid_to_wbu}, 32'd0);
    @(negedge clk);
    rst            = 1'b1;
    bus.mem_rvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_wbu_valid", {31'h0, bus.is_req_valid_to_wbu}, 32'd0);
      chk("post_rst_mem_req", {31'h0, bus.mem_req_valid}, 32'd0);
      chk("post_rst_exu_ready", {31'h0, bus.is_req_ready_to_exu}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25040129_lsu_ctrl.md
Name: ysyx_25040129_lsu_ctrl

Overview:
Load/store unit. It is the responder on the EXU→LSU valid/ready request channel. It accepts one decoded instruction per handshake and performs the load or store on a simple single-outstanding memory bus. Loads are aligned and sign/zero-extended, stores get byte strobes, and the writeback bundle is then offered to the WBU on a second valid/ready channel. Non-memory instructions pass through in one state without touching the bus.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, data width; only 32 is supported

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
is_req_valid_from_exu  in  1  EXU offers an instruction
is_req_ready_to_exu  out  1  LSU can accept; high only in IDLE
pc_in_lsu  in  32  instruction PC
result_in_lsu  in  32  ALU result; this is the effective address for memory ops
lsu_write_data_in_lsu  in  32  store data, unshifted, in low bits
lsu_read_in_lsu  in  3  000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU
lsu_write_in_lsu  in  2  00 none, 01 SB, 10 SH, 11 SW
rd_in_lsu / reg_write_in_lsu  in  5/1  destination register and write enable, passed through
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts the request
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wen  out  1  1 = write
mem_wdata  out  32  data shifted into byte lanes
mem_wstrb  out  4  byte strobes
mem_rvalid  in  1  response valid; for a write this is the write acknowledge
mem_rdata  in  32  read word
is_req_valid_to_wbu  out  1  writeback bundle valid
is_req_ready_from_wbu  in  1  WBU accepts the bundle
pc_out_lsu / result_out_lsu / rd_out_lsu / reg_write_out_lsu  out  32/32/5/1  writeback bundle
misalign_fault_out_lsu  out  1  misaligned access flag, valid with is_req_valid_to_wbu

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all registered outputs 0; mem_req_valid=0; is_req_valid_to_wbu=0; is_req_ready_to_exu=1 once rst is released.
- Inputs are captured into holding registers on the EXU handshake (valid&&ready in IDLE). EXU inputs are ignored at all other times.
- States:
  - IDLE: on handshake, go to ACCESS if the op is a load/store and aligned; otherwise go to DONE.
  - ACCESS: mem_req_valid=1, address and strobes stable. On mem_req_ready, go to WAIT.
  - WAIT: on mem_rvalid, latch the formatted result and go to DONE.
  - DONE: is_req_valid_to_wbu=1 and the bundle is held stable. On is_req_ready_from_wbu, go to IDLE.
- Latency is counted from the EXU handshake to WBU valid:
  - non-memory op: 1 cycle;
  - memory op: 1 + request-wait cycles + response-wait cycles, so minimum 3 cycles when ready and rvalid are each high in the first cycle of their state.
- mem_rvalid is honoured in WAIT only. If it is asserted in the same cycle that ACCESS sees mem_req_ready, it is ignored; the memory must hold it or return it in a later cycle.
- mem_rvalid arriving in any state other than WAIT is ignored.
- Misalignment:
  - LH/LHU/SH with addr[0]=1 is misaligned.
  - LW/SW with addr[1:0]≠0 is misaligned.
  - A misaligned op does not touch the bus. It goes straight to DONE with misalign_fault_out_lsu=1, reg_write_out_lsu forced to 0, and result_out_lsu = address.
- Store lanes:
  - SB: wstrb = 1<<addr[1:0]; wdata = byte replicated ×4.
  - SH: wstrb = 0011<<addr[1:0]; wdata = half replicated ×2.
  - SW: wstrb = 1111.
  - result_out_lsu = 0 and reg_write_out_lsu = 0 for stores.
- Load format: select the byte/half of mem_rdata by addr[1:0], then sign-extend (LB, LH) or zero-extend (LBU, LHU). LW passes the word through.
- Non-memory op: result_out_lsu = result_in_lsu; rd and reg_write pass through.
- If both a read and a write encoding are non-zero, the read takes priority and the write field is ignored.
- Illegal read encodings 110 and 111 are treated as none.
- The handshake is single-entry and there is no skid buffer. EXU back-pressure comes solely from is_req_ready_to_exu.

Decomposition:
- Shared package: read encodings (LB, LH, LW, LBU, LHU), write encodings (SB, SH, SW), and the LSU state localparams.
- One sub-module, ysyx_25040129_lsu_align. It is combinational: from op and addr[1:0] it produces wstrb/wdata, the loaded-data extension, and the misalign flag. This keeps the FSM file under 200 lines.

Test Plan:
- ALU op, result_in=0x1234, WBU ready → WBU valid 1 cycle after the handshake; result_out=0x1234; no mem_req_valid pulse.
- LB at addr 0x80000003, mem_rdata=0x80AABBCC → mem_addr=0x80000000; result_out=0xFFFFFF80. Repeat with LBU → 0x00000080.
- SH at addr 0x80000002, data=0xDEADBEEF, mem_req_ready delayed 3 cycles → mem_wstrb=1100, mem_wdata=0xBEEFBEEF; request held stable over the 3 cycles; reg_write_out=0.
- LW at addr 0x80000001 → no bus request; WBU valid with misalign_fault_out=1, reg_write_out=0, result_out=0x80000001.
- WBU ready held low for 5 cycles in DONE → bundle stable; is_req_ready_to_exu=0; a second EXU valid is not accepted until WBU handshakes.
- rst driven low while in WAIT → all outputs reset immediately (asynchronously); after release the FSM is in IDLE and a late mem_rvalid is ignored.
